// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dm_store_buffer
// Brief    : Posted-write FIFO between the CPU data port and the word-addressed
//            data memory. Stores are queued and drained into memory in any
//            cycle without a load. Loads forward from the youngest matching
//            queued store or fall through to memory.
// Revision : 1.0 - initial release
// ============================================================================
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int PW    = 2
) (
  input  logic          CLK_I,
  input  logic          RESET_I,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [31:0]   cpu_wdata_i,
  input  logic          cpu_we_i,
  input  logic          cpu_re_i,
  output logic [31:0]   cpu_rdata_o,
  output logic          cpu_stall_o,
  output logic [AW-1:0] dm_addr_o,
  output logic [31:0]   dm_wdata_o,
  output logic          dm_we_o,
  input  logic [31:0]   dm_rdata_i,
  output logic [PW:0]   count_o,
  output logic          empty_o
);

  localparam logic [PW:0] C_FULL_COUNT = (PW+1)'(DEPTH);

  // Entry storage; only the valid bits carry reset state.
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic full;
  logic load;
  logic store_ok;
  logic drain;

  // Request decode: a store masks a simultaneous load; anything that is not a
  // load lets the head entry drain, including a store cycle.
  assign full     = (count == C_FULL_COUNT);
  assign load     = cpu_re_i & ~cpu_we_i;
  assign store_ok = cpu_we_i & ~full;
  assign drain    = ~load & (count != '0);

  assign cpu_stall_o = RESET_I & cpu_we_i & full;
  assign count_o     = count;
  assign empty_o     = (count == '0);

  // Memory port mux: drain takes the port, otherwise the CPU address passes
  // through; reset blocks any write so a pending drain is never committed.
  always_comb begin
    dm_we_o    = 1'b0;
    dm_addr_o  = cpu_addr_i;
    dm_wdata_o = '0;
    if (!RESET_I) begin
      dm_addr_o = '0;
    end else if (drain) begin
      dm_we_o    = 1'b1;
      dm_addr_o  = ent_addr[head];
      dm_wdata_o = ent_data[head];
    end
  end

  // Load forwarding: scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    cpu_rdata_o = dm_rdata_i;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[head + PW'(i)] && (ent_addr[head + PW'(i)] == cpu_addr_i)) begin
        cpu_rdata_o = ent_data[head + PW'(i)];
      end
    end
  end

  // Entry payload capture at the tail slot on an accepted store.
  always_ff @(posedge CLK_I) begin
    if (store_ok) begin
      ent_addr[tail] <= cpu_addr_i;
      ent_data[tail] <= cpu_wdata_i;
    end
  end

  // Pointer, occupancy and valid-bit bookkeeping.
  always_ff @(posedge CLK_I or negedge RESET_I) begin
    if (!RESET_I) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (store_ok) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      case ({store_ok, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire
